// File: rtl/worksheet_solver.sv
// worksheet_solver: evaluates a worksheet of add/multiply problems streamed one column at a time.
// Ports: clk, rst_n (async active-low); mode (0 row-wise, 1 column-wise operands);
// s_valid/s_ready/s_data/s_op/s_last column beat stream; done, result (grand total),
// problem_count, error (sticky per worksheet).
module worksheet_solver #(
    parameter int ROWS     = 4,
    parameter int MAX_COLS = 4,
    parameter int ACC_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [4*ROWS-1:0] s_data,
    input  logic [1:0]        s_op,
    input  logic              s_last,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic [15:0]       problem_count,
    output logic              error
);
    localparam int CW = $clog2(MAX_COLS + 1);
    localparam int IW = $clog2((ROWS > MAX_COLS ? ROWS : MAX_COLS) + 1);
    typedef enum logic [2:0] {IDLE, COLLECT, REDUCE, ACCUM, DONE} state_t;
    state_t state, state_nx;
    logic mode_q, last_q;
    logic [1:0] op_q, op_nx;
    logic [CW-1:0] ncols;
    logic [IW-1:0] idx, idx_last;
    logic [ACC_W-1:0] row_val [ROWS];
    logic [ACC_W-1:0] col_buf [MAX_COLS];
    logic [ROWS-1:0] row_has, digit;
    logic [ACC_W-1:0] acc, col_val, operand;
    logic accept, start, is_data, is_sep, has_digits, close, empty_last, op_err, overflow, present;
    // Column value: the non-blank digits of this beat read top to bottom as one decimal number.
    always_comb begin
        digit = '0;
        col_val = '0;
        for (int r = 0; r < ROWS; r++) begin
            digit[r] = s_data[4*r +: 4] < 4'd10;
            col_val = digit[r] ? col_val * ACC_W'(10) + ACC_W'(s_data[4*r +: 4]) : col_val;
        end
    end
    assign s_ready    = state == IDLE || state == COLLECT || state == DONE;
    assign done       = state == DONE;
    assign accept     = s_valid && s_ready;
    assign start      = accept && (state == IDLE || state == DONE);
    assign is_data    = |digit;
    assign is_sep     = !is_data && s_op == 2'b00;
    assign has_digits = ncols != '0 || is_data;
    assign close      = accept && (is_sep || s_last) && has_digits;
    // A final beat that leaves the open problem empty ends the worksheet without a reduction.
    assign empty_last = accept && s_last && !has_digits;
    assign op_nx      = op_q == 2'b00 && (s_op == 2'b01 || s_op == 2'b10) ? s_op : op_q;
    assign op_err     = s_op == 2'b11 || (s_op != 2'b00 && op_q != 2'b00 && s_op != op_q);
    assign overflow   = is_data && ncols == CW'(MAX_COLS);
    assign idx_last   = mode_q ? IW'(ncols) - 1'b1 : IW'(ROWS - 1);
    // Operand select by comparison keeps index widths independent of array sizes.
    always_comb begin
        operand = '0;
        present = 1'b0;
        for (int i = 0; i < ROWS; i++)
            if (!mode_q && idx == IW'(i)) begin
                operand = row_val[i];
                present = row_has[i];
            end
        for (int i = 0; i < MAX_COLS; i++)
            if (mode_q && idx == IW'(i)) begin
                operand = col_buf[i];
                present = 1'b1;
            end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, COLLECT, DONE: state_nx = close ? REDUCE : empty_last ? DONE : accept ? COLLECT : state;
            REDUCE:              state_nx = idx == idx_last ? ACCUM : REDUCE;
            ACCUM:               state_nx = last_q ? DONE : COLLECT;
            default:             state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mode_q        <= 1'b0;
            last_q        <= 1'b0;
            op_q          <= 2'b00;
            ncols         <= '0;
            idx           <= '0;
            acc           <= '0;
            result        <= '0;
            problem_count <= '0;
            error         <= 1'b0;
            row_has       <= '0;
            for (int r = 0; r < ROWS; r++) row_val[r] <= '0;
            for (int c = 0; c < MAX_COLS; c++) col_buf[c] <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                mode_q        <= mode;
                result        <= '0;
                problem_count <= '0;
            end
            if (accept) begin
                for (int r = 0; r < ROWS; r++)
                    if (digit[r]) begin
                        row_val[r] <= row_val[r] * ACC_W'(10) + ACC_W'(s_data[4*r +: 4]);
                        row_has[r] <= 1'b1;
                    end
                for (int c = 0; c < MAX_COLS; c++)
                    if (is_data && ncols == CW'(c)) col_buf[c] <= col_val;
                if (is_data && !overflow) ncols <= ncols + 1'b1;
                op_q   <= empty_last ? 2'b00 : op_nx;
                last_q <= s_last;
                idx    <= '0;
                acc    <= op_nx == 2'b10 ? ACC_W'(1) : '0;
                error  <= (error && !start) || op_err || overflow || (close && op_nx == 2'b00);
            end
            if (state == REDUCE) begin
                idx <= idx + 1'b1;
                if (present) acc <= op_q == 2'b01 ? acc + operand : op_q == 2'b10 ? acc * operand : acc;
            end
            if (state == ACCUM) begin
                result        <= result + acc;
                problem_count <= problem_count + 1'b1;
                op_q          <= 2'b00;
                ncols         <= '0;
                row_has       <= '0;
                for (int r = 0; r < ROWS; r++) row_val[r] <= '0;
            end
        end
    end
endmodule

// File: doc/worksheet_solver.md
WORKSHEET_SOLVER -- requirements
Module: worksheet_solver

Interface
REQ-001 Parameter ROWS, default 4, number of digit rows per worksheet column.
REQ-002 Parameter MAX_COLS, default 4, maximum digit columns per problem.
REQ-003 Parameter ACC_W, default 64, width of all accumulators and result.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mode  input  1  0 = row-wise numbers (part 1), 1 = column-wise numbers (part 2).
REQ-007 s_valid  input  1  column beat valid.
REQ-008 s_ready  output  1  block accepts a beat when s_valid and s_ready are both high.
REQ-009 s_data  input  4*ROWS  one nibble per row, row 0 in bits [3:0] (top row); value 0-9 is a digit, any value >9 is blank.
REQ-010 s_op  input  2  operator-row symbol: 00 none, 01 add, 10 multiply, 11 reserved (treated as none, sets error).
REQ-011 s_last  input  1  marks final beat of the worksheet.
REQ-012 done  output  1  high when result is final.
REQ-013 result  output  ACC_W  grand total of all problem answers.
REQ-014 problem_count  output  16  number of problems reduced in current worksheet.
REQ-015 error  output  1  sticky error flag for current worksheet.

Function
REQ-016 States SHALL be IDLE, COLLECT, REDUCE, ACCUM, DONE.
REQ-017 A separator beat SHALL be one with all nibbles blank and s_op = 00.
REQ-018 IDLE: s_ready high; first accepted beat latches mode, clears result/problem_count/error/done, is processed as in COLLECT; next state COLLECT.
REQ-019 COLLECT data beat: column value = decimal number of non-blank digits top-to-bottom, stored in column buffer slot ncols, ncols increments.
REQ-020 COLLECT data beat: every row r with a non-blank digit d updates row_val[r] = row_val[r]*10 + d (ACC_W wide).
REQ-021 First non-zero, non-reserved s_op in a problem SHALL latch as problem operator; a later differing one is ignored and sets error.
REQ-022 Separator beat or s_last beat (after processing its data) SHALL close the problem: s_ready drops next cycle, state REDUCE.
REQ-023 Separator with ncols = 0 (consecutive separators, leading separator) SHALL be dropped: no REDUCE, count unchanged, s_ready stays high.
REQ-024 REDUCE: one operand per cycle; operands are row_val[0..ROWS-1] if mode = 0, column buffer [0..ncols-1] if mode = 1; cycles = ROWS or ncols.
REQ-025 Operand of zero digits (empty row) SHALL be skipped (no effect on either operator) but still consumes its cycle.
REQ-026 acc starts 0 for add, 1 for multiply; acc = acc+op or acc*op, modulo 2^ACC_W.
REQ-027 Problem with digits but no latched operator SHALL contribute 0 and set error.
REQ-028 ACCUM (1 cycle): result += acc (mod 2^ACC_W), problem_count += 1, row_val/ncols/operator cleared; next COLLECT with s_ready high, or DONE if closing beat had s_last.
REQ-029 s_ready SHALL be low for exactly N+1 cycles per closed problem (N = REDUCE cycles).
REQ-030 More than MAX_COLS data columns in one problem: extra column values dropped from buffer (row_val still updated), error set.
REQ-031 DONE: done high, result/problem_count/error stable, s_ready high; an accepted beat behaves as in IDLE (new worksheet, done low next cycle).
REQ-032 mode changes outside IDLE/DONE acceptance SHALL be ignored.
REQ-033 s_data/s_op/s_last SHALL be ignored when s_valid or s_ready is low.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, s_ready=1 (after release), done=0, result=0, problem_count=0, error=0, all buffers and accumulators cleared.
REQ-035 Reset asserted mid-REDUCE or mid-stream SHALL discard the partial problem; the stream restarts cleanly after release.

Verification
REQ-036 ROWS=3, MAX_COLS=3, mode=0, AoC example ("123 45 6 *", "328 64 98 +", "51 387 215 *", "64 23 314 +") as columns with separators, s_last on final column -> result=4277556, problem_count=4, error=0.
REQ-037 Same stream, mode=1 -> result=3263827, problem_count=4, error=0; first problem column values 1,24,356 yield 8544.
REQ-038 Two consecutive separators plus random s_valid gaps -> identical totals; s_ready low exactly ROWS+1 (mode 0) or ncols+1 (mode 1) cycles per problem.
REQ-039 Problem with 4 digit columns, MAX_COLS=3, mode=1 -> 4th column dropped, error=1; problem with no op -> contributes 0, error=1.
REQ-040 rst_n pulsed low during REDUCE of problem 2 -> outputs zero immediately; replaying full stream gives REQ-036 values.
REQ-041 New worksheet beat in DONE -> done falls next cycle, result/problem_count restart from 0.
